mem_loader_responder: RTL and testbench
=======================================

Name: mem_loader_responder

Overview:
Memory-side responder for the 8-bit CPU memory interface. It serves Mem_ADDR, Mem_IN and write from the core and returns Mem_OUT. It contains a 256x8 RAM and one memory-mapped I/O byte. A byte-serial boot loader FSM fills RAM from an external stream while holding the CPU in reset, then releases it.

Parameters:
IO_ADDR, 8'hFF, address decoded as the I/O port (not a RAM location for reads)
AUTO_RUN, 0, 1 = leave reset directly in RUN (no load); 0 = leave reset in IDLE

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high
Mem_ADDR  input  8  CPU address
Mem_IN  input  8  CPU write data
write  input  1  CPU write strobe
Mem_OUT  output  8  read data to CPU
ld_start  input  1  one-cycle pulse: begin (or restart) a load
ld_valid  input  1  loader byte valid
ld_data  input  8  loader byte
ld_ready  output  1  responder accepts a loader byte
load_done  output  1  one-cycle pulse when the last byte is written
cpu_reset  output  1  reset to the CPU core; high whenever state != RUN
io_in  input  8  external input byte, read at IO_ADDR
io_out  output  8  latched output byte, written at IO_ADDR

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: state = RUN if AUTO_RUN else IDLE; io_out = 0; load count = 0; load_done = 0. ld_ready and cpu_reset are decoded from state. RAM contents are NOT reset and are retained across reset.
- Read path:
  - Asynchronous (combinational) read, zero latency.
  - Mem_OUT = io_in when Mem_ADDR == IO_ADDR, else ram[Mem_ADDR].
  - Valid in every state.
- CPU write:
  - Occurs in RUN only. At posedge, write=1 stores Mem_IN.
  - If Mem_ADDR == IO_ADDR, the value goes to io_out only (RAM untouched). Otherwise it goes to ram[Mem_ADDR].
  - write is ignored in IDLE/LEN/LOAD.
- FSM states: IDLE, LEN, LOAD, RUN.
  - IDLE: cpu_reset=1, ld_ready=0. ld_start -> LEN.
  - LEN: cpu_reset=1, ld_ready=1. On handshake (ld_valid && ld_ready): length N = ld_data (0 means 256), address ptr = 0, -> LOAD.
  - LOAD: cpu_reset=1, ld_ready=1. Each handshake writes ram[ptr] = ld_data (including ptr == IO_ADDR, so the loader can fill all 256 bytes), then ptr++ and remaining--. On the handshake of the final byte: load_done=1 next cycle, -> RUN.
  - RUN: cpu_reset=0, ld_ready=0. ld_start -> LEN (CPU re-held in reset from the next cycle).
- Counters: ptr is 8-bit and wraps 8'hFF -> 8'h00 only after the 256th byte, at which point the load ends. remaining is 9-bit.
- Handshake rules: a transfer occurs only on a cycle with ld_valid && ld_ready. ld_valid low stalls indefinitely with no timeout. ld_data is sampled only on transfer cycles.
- Simultaneous events:
  - ld_start in LEN or LOAD restarts to LEN. ptr and remaining are discarded; any handshake in the same cycle is ignored.
  - ld_start has priority over a handshake.
  - reset has priority over everything.
- Reset mid-load: returns to IDLE (or RUN if AUTO_RUN). Bytes already written stay in RAM.
- load_done: exactly one cycle, coincident with the first cycle of RUN.

Test Plan:
- Reset with AUTO_RUN=0 -> cpu_reset=1, ld_ready=0, io_out=8'h00. Pulse ld_start -> ld_ready=1 next cycle.
- Load N=3, bytes 8'h12, 8'h34, 8'h56 with ld_valid toggling -> ram[0..2] = 12,34,56. load_done pulses once. cpu_reset falls in the same cycle. Mem_ADDR=1 gives Mem_OUT=8'h34 combinationally.
- N=0 (256 bytes), data = address ^ 8'hA5 -> all 256 locations correct. Load ends after exactly 256 transfers; ptr wraps to 0.
- In RUN, write=1, Mem_ADDR=8'hFF, Mem_IN=8'h5A -> io_out=8'h5A, RAM unchanged. With io_in=8'hC3, reading 8'hFF gives Mem_OUT=8'hC3. Write at 8'h10 stores and reads back.
- ld_start asserted in the same cycle as the 2nd byte handshake of a 4-byte load -> state LEN, that byte not written. New length then accepted.
- reset asserted mid-load after 2 of 5 bytes -> IDLE, cpu_reset=1, ram[0..1] retain loaded values. In IDLE or LOAD, write=1 changes nothing.

Source files
------------

// File: rtl/mem_loader_responder.sv
// 256x8 RAM plus one I/O byte behind the CPU port, and a byte-serial boot loader that keeps the CPU in reset while it fills RAM.
// Reads are combinational. The loader stream is valid/ready and stalls indefinitely while ld_valid is low.
module mem_loader_responder #(
  parameter logic [7:0] IO_ADDR  = 8'hFF,
  parameter bit         AUTO_RUN = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Mem_ADDR,
  input  logic [7:0] Mem_IN,
  input  logic       write,
  output logic [7:0] Mem_OUT,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       load_done,
  output logic       cpu_reset,
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {IDLE, LEN, LOAD, RUN} state_t;

  state_t     state, state_nxt;
  logic [7:0] ram [0:255];
  logic [7:0] ptr;
  logic [8:0] remaining;
  logic       xfer;
  logic       last_byte;
  logic       load_we;
  logic       cpu_ram_we;
  logic       cpu_io_we;

  assign xfer       = ld_valid && ld_ready;
  assign last_byte  = (state == LOAD) && xfer && !ld_start && (remaining == 9'd1);
  assign load_we    = (state == LOAD) && xfer && !ld_start;
  assign cpu_ram_we = (state == RUN) && write && (Mem_ADDR != IO_ADDR);
  assign cpu_io_we  = (state == RUN) && write && (Mem_ADDR == IO_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= AUTO_RUN ? RUN : IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ld_start wins over any same-cycle handshake in every state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_start) state_nxt = LEN;
      LEN: begin
        if (ld_start)  state_nxt = LEN;
        else if (xfer) state_nxt = LOAD;
      end
      LOAD: begin
        if (ld_start)       state_nxt = LEN;
        else if (last_byte) state_nxt = RUN;
      end
      RUN:     if (ld_start) state_nxt = LEN;
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    cpu_reset = 1'b1;
    ld_ready  = 1'b0;
    case (state)
      IDLE:    begin cpu_reset = 1'b1; ld_ready = 1'b0; end
      LEN:     begin cpu_reset = 1'b1; ld_ready = 1'b1; end
      LOAD:    begin cpu_reset = 1'b1; ld_ready = 1'b1; end
      RUN:     begin cpu_reset = 1'b0; ld_ready = 1'b0; end
      default: begin cpu_reset = 1'b1; ld_ready = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= 8'h00;
      remaining <= 9'd0;
      load_done <= 1'b0;
      io_out    <= 8'h00;
    end else begin
      load_done <= last_byte;
      if (cpu_io_we) io_out <= Mem_IN;
      if (state == LEN && xfer && !ld_start) begin
        // A length byte of zero encodes a full 256-byte image.
        remaining <= (ld_data == 8'h00) ? 9'd256 : {1'b0, ld_data};
        ptr       <= 8'h00;
      end else if (load_we) begin
        ptr       <= ptr + 8'd1;
        remaining <= remaining - 9'd1;
      end
    end
  end

  // RAM has no reset so its contents survive a CPU or loader reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (load_we)         ram[ptr]      <= ld_data;
      else if (cpu_ram_we) ram[Mem_ADDR] <= Mem_IN;
    end
  end

  assign Mem_OUT = (Mem_ADDR == IO_ADDR) ? io_in : ram[Mem_ADDR];

endmodule

// File: tb/tb_mem_loader_responder.sv
// Directed bench for mem_loader_responder: a transaction-level model checked every cycle, plus literal spot checks.
module tb_mem_loader_responder;

  localparam logic [7:0] IO_A = 8'hFF;
  localparam int M_IDLE = 0, M_WAITLEN = 1, M_FILL = 2, M_RUN = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Mem_ADDR, Mem_IN, Mem_OUT;
  logic       write;
  logic       ld_start, ld_valid, ld_ready, load_done, cpu_reset;
  logic [7:0] ld_data, io_in, io_out;

  int checks = 0;
  int errors = 0;

  // Model state: what software-visible behaviour must look like.
  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_io;
  int         m_mode;
  int         m_left;
  int         m_next;
  bit         m_done;
  bit         chk_en = 1'b0;

  mem_loader_responder #(.IO_ADDR(8'hFF), .AUTO_RUN(1'b0)) dut (
    .clk(clk), .reset(reset), .Mem_ADDR(Mem_ADDR), .Mem_IN(Mem_IN), .write(write),
    .Mem_OUT(Mem_OUT), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .load_done(load_done), .cpu_reset(cpu_reset),
    .io_in(io_in), .io_out(io_out)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_mode = M_IDLE;
      m_io   = 8'h00;
      m_done = 1'b0;
      chk_en = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_mode == M_RUN && write) begin
        if (Mem_ADDR == IO_A) m_io = Mem_IN;
        else begin
          m_mem[Mem_ADDR]   = Mem_IN;
          m_known[Mem_ADDR] = 1'b1;
        end
      end
      if (ld_start) begin
        m_mode = M_WAITLEN;
      end else if (ld_valid && m_mode == M_WAITLEN) begin
        m_left = (ld_data == 0) ? 256 : int'(ld_data);
        m_next = 0;
        m_mode = M_FILL;
      end else if (ld_valid && m_mode == M_FILL) begin
        m_mem[m_next]   = ld_data;
        m_known[m_next] = 1'b1;
        m_next = (m_next + 1) % 256;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = M_RUN;
          m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk1("cpu_reset", cpu_reset, m_mode != M_RUN);
      chk1("ld_ready", ld_ready, m_mode == M_WAITLEN || m_mode == M_FILL);
      chk1("load_done", load_done, m_done);
      chk8("io_out", io_out, m_io);
      if (Mem_ADDR == IO_A) chk8("mem_out_io", Mem_OUT, io_in);
      else if (m_known[Mem_ADDR]) chk8("mem_out_ram", Mem_OUT, m_mem[Mem_ADDR]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int gaps);
    ld_valid = 1'b0;
    repeat (gaps) tick();
    ld_valid = 1'b1;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    Mem_ADDR = a;
    #1;
    chk8(name, Mem_OUT, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    reset = 1'b1; Mem_ADDR = 8'h00; Mem_IN = 8'h00; write = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; io_in = 8'h3C;
    tick(); tick();
    reset = 1'b0;
    chk1("rst_cpu_reset", cpu_reset, 1'b1);
    chk1("rst_ld_ready", ld_ready, 1'b0);
    chk8("rst_io_out", io_out, 8'h00);

    pulse_start();
    chk1("start_ready", ld_ready, 1'b1);

    // Three-byte image with ld_valid toggling between bytes.
    send(8'd3, 1);
    send(8'h12, 1);
    send(8'h34, 2);
    send(8'h56, 1);
    chk1("n3_done", load_done, 1'b1);
    chk1("n3_cpu_reset", cpu_reset, 1'b0);
    read_chk("n3_rd1", 8'h01, 8'h34);
    read_chk("n3_rd0", 8'h00, 8'h12);
    read_chk("n3_rd2", 8'h02, 8'h56);
    tick();
    chk1("n3_done_once", load_done, 1'b0);

    // Full 256-byte image, length byte 0.
    pulse_start();
    send(8'h00, 0);
    for (int a = 0; a < 255; a++) send(8'(a) ^ 8'hA5, 0);
    chk1("n256_still_held", cpu_reset, 1'b1);
    send(8'hFF ^ 8'hA5, 0);
    chk1("n256_done", load_done, 1'b1);
    for (int a = 0; a < 255; a++) read_chk("n256_rd", 8'(a), 8'(a) ^ 8'hA5);

    // CPU writes in RUN.
    write = 1'b1; Mem_ADDR = 8'hFF; Mem_IN = 8'h5A;
    tick();
    write = 1'b0;
    chk8("io_write", io_out, 8'h5A);
    io_in = 8'hC3;
    read_chk("io_read", 8'hFF, 8'hC3);
    read_chk("io_ram_untouched", 8'h00, 8'hA5);
    write = 1'b1; Mem_ADDR = 8'h10; Mem_IN = 8'h77;
    tick();
    write = 1'b0;
    read_chk("cpu_wr_10", 8'h10, 8'h77);

    // Restart on the second data byte of a 4-byte load.
    pulse_start();
    send(8'd4, 0);
    send(8'h11, 0);
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h22;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    chk1("restart_ready", ld_ready, 1'b1);
    read_chk("restart_not_written", 8'h01, 8'hA4);
    read_chk("restart_byte0", 8'h00, 8'h11);
    send(8'd2, 1);
    send(8'h66, 0);
    send(8'h77, 0);
    chk1("restart_done", load_done, 1'b1);
    read_chk("restart_rd0", 8'h00, 8'h66);
    read_chk("restart_rd1", 8'h01, 8'h77);

    // Reset after 2 of 5 bytes, then writes outside RUN are ignored.
    pulse_start();
    send(8'd5, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("midrst_cpu_reset", cpu_reset, 1'b1);
    chk1("midrst_ld_ready", ld_ready, 1'b0);
    chk8("midrst_io_out", io_out, 8'h00);
    read_chk("midrst_rd0", 8'h00, 8'hAA);
    read_chk("midrst_rd1", 8'h01, 8'hBB);
    write = 1'b1; Mem_ADDR = 8'h03; Mem_IN = 8'h99;
    tick();
    Mem_ADDR = 8'hFF;
    tick();
    write = 1'b0;
    chk8("idle_io_ignored", io_out, 8'h00);
    read_chk("idle_wr_ignored", 8'h03, 8'hA6);
    pulse_start();
    send(8'd1, 0);
    write = 1'b1; Mem_ADDR = 8'h05; Mem_IN = 8'hEE;
    tick();
    write = 1'b0;
    read_chk("load_wr_ignored", 8'h05, 8'hA0);
    send(8'h01, 1);
    chk1("last_done", load_done, 1'b1);
    read_chk("last_rd0", 8'h00, 8'h01);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
